// File: rtl/finder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : finder_pkg
//  Description : Shared definitions for the instruction fetch front-end:
//                default instruction / address widths, opcode constants used
//                by the decode side, and the prefetch buffer entry type.
//  Contents    : WIDTH_INSTR, WIDTH_JDATA  - default widths
//                OP_*                      - 4-bit opcode constants
//                fetch_entry_t             - {pc, instr} buffered entry
//  Revision    : 1.0 - initial release
// ============================================================================
package finder_pkg;

    localparam int WIDTH_INSTR = 16;
    localparam int WIDTH_JDATA = 24;

    localparam logic [3:0] OP_JZ  = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b1011;
    localparam logic [3:0] OP_LD  = 4'b1100;
    localparam logic [3:0] OP_NOP = 4'b1101;

    // One prefetched instruction together with the address it was read from.
    typedef struct packed {
        logic [WIDTH_JDATA-1:0] pc;
        logic [WIDTH_INSTR-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fifo
//  Description : Synchronous prefetch FIFO of fetch_entry_t with a flush.
//                Flush has priority over push and pop in the same cycle.
//                Simultaneous push and pop both happen; count is unchanged.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                flush                 - empty the buffer at the clock edge
//                push, push_data       - write one entry
//                pop                   - drop the head entry (ignored if empty)
//                head                  - head entry (don't-care when empty)
//                not_empty             - head entry present
//                count                 - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo
    import finder_pkg::*;
#(
    parameter int DEPTH   = 4,                 // power of 2, >= 2
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic               not_empty,
    output logic [COUNT_W-1:0] count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] c_DEPTH = COUNT_W'(DEPTH);

    fetch_entry_t        r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [COUNT_W-1:0]  r_count;

    logic                w_do_pop;
    logic                w_full;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_full    = (r_count == c_DEPTH);
    assign not_empty = (r_count != '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)     r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    // The fetch credit scheme guarantees a free slot for every returning word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && w_full));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch front-end. Keeps the PC, issues reads to a
//                1-cycle-latency synchronous instruction memory, buffers the
//                returned words in a prefetch FIFO and hands them to the
//                decode controller over the instr/valid/next_instr handshake.
//                A jump flushes the buffer and discards the in-flight read.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                run                   - allow new memory reads
//                jump, jdata           - redirect request and target
//                next_instr            - consumer pops head when valid
//                instr, valid, instr_pc- head instruction / present / address
//                imem_en, imem_addr    - memory read strobe and address
//                imem_rdata            - read data, one cycle after imem_en
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import finder_pkg::fetch_entry_t;
#(
    parameter int                     WIDTH_INSTR = finder_pkg::WIDTH_INSTR,
    parameter int                     WIDTH_JDATA = finder_pkg::WIDTH_JDATA,
    parameter int                     FIFO_DEPTH  = 4,
    parameter logic [WIDTH_JDATA-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   jump,
    input  logic [WIDTH_JDATA-1:0] jdata,
    input  logic                   next_instr,
    output logic [WIDTH_INSTR-1:0] instr,
    output logic                   valid,
    output logic [WIDTH_JDATA-1:0] instr_pc,
    output logic                   imem_en,
    output logic [WIDTH_JDATA-1:0] imem_addr,
    input  logic [WIDTH_INSTR-1:0] imem_rdata
);

    localparam int             COUNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COUNT_W:0] c_DEPTH = (COUNT_W + 1)'(FIFO_DEPTH);

    logic [WIDTH_JDATA-1:0] r_pc;
    logic [WIDTH_JDATA-1:0] r_req_pc;     // address of the read in flight
    logic                   r_inflight;

    logic [COUNT_W-1:0]     w_count;
    logic [COUNT_W:0]       w_occupancy;
    logic                   w_has_credit;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_not_empty;
    fetch_entry_t           w_push_entry;
    fetch_entry_t           w_head;

    // Stored entries plus the word still coming back must fit in the buffer.
    assign w_occupancy  = {1'b0, w_count} + {{COUNT_W{1'b0}}, r_inflight};
    assign w_has_credit = (w_occupancy < c_DEPTH);

    // A jump flushes the buffer, so it may always issue its target read.
    // rst_n gates the strobe so no read leaves while reset is held.
    assign w_issue   = rst_n && run && (jump || w_has_credit);
    assign imem_en   = w_issue;
    assign imem_addr = jump ? jdata : r_pc;

    // With 1-cycle memory latency the only outstanding read at a jump returns
    // in the jump cycle itself, so killing it means suppressing this push.
    assign w_push = r_inflight && !jump;
    assign w_pop  = next_instr && w_not_empty && !jump;

    assign w_push_entry = '{pc: r_req_pc, instr: imem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_req_pc <= imem_addr;
            if (jump) begin
                // With run=1 the target was read this cycle; continue after it.
                r_pc <= run ? (jdata + 1'b1) : jdata;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    instr_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .COUNT_W (COUNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (jump),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .not_empty (w_not_empty),
        .count     (w_count)
    );

    assign valid    = w_not_empty;
    assign instr    = w_head.instr;
    assign instr_pc = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch. Two instances
//                share all inputs: one with RESET_PC=0, one with
//                RESET_PC=0xFFFFFE to exercise PC wrap-around. Each memory
//                model returns the low 16 bits of the requested address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        jump;
    logic [23:0] jdata;
    logic        next_instr;

    logic [15:0] instr,  instr2;
    logic        valid,  valid2;
    logic [23:0] instr_pc, instr_pc2;
    logic        imem_en, imem_en2;
    logic [23:0] imem_addr, imem_addr2;
    logic [15:0] imem_rdata = '0;
    logic [15:0] imem_rdata2 = '0;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .WIDTH_INSTR (16),
        .WIDTH_JDATA (24),
        .FIFO_DEPTH  (4),
        .RESET_PC    (24'h000000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .jump       (jump),
        .jdata      (jdata),
        .next_instr (next_instr),
        .instr      (instr),
        .valid      (valid),
        .instr_pc   (instr_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata)
    );

    instr_fetch #(
        .WIDTH_INSTR (16),
        .WIDTH_JDATA (24),
        .FIFO_DEPTH  (4),
        .RESET_PC    (24'hFFFFFE)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .jump       (jump),
        .jdata      (jdata),
        .next_instr (next_instr),
        .instr      (instr2),
        .valid      (valid2),
        .instr_pc   (instr_pc2),
        .imem_en    (imem_en2),
        .imem_addr  (imem_addr2),
        .imem_rdata (imem_rdata2)
    );

    // Synchronous memories, 1-cycle read latency, word = address[15:0].
    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= imem_addr[15:0];
        if (imem_en2) imem_rdata2 <= imem_addr2[15:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; jump = 1'b0; jdata = '0; next_instr = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst_valid",   32'(valid),    32'd0);
        chk("rst_en",      32'(imem_en),  32'd0);
        chk("rst_valid2",  32'(valid2),   32'd0);
        chk("rst_en2",     32'(imem_en2), 32'd0);

        // ---- streaming from reset ----
        rst_n = 1'b1; #1;
        chk("c0_en",    32'(imem_en),    32'd1);
        chk("c0_addr",  32'(imem_addr),  32'h0);
        chk("c0_valid", 32'(valid),      32'd0);
        chk("c0_addr2", 32'(imem_addr2), 32'hFFFFFE);
        tick(); #1;
        chk("c1_addr",  32'(imem_addr),  32'h1);
        chk("c1_valid", 32'(valid),      32'd0);
        chk("c1_addr2", 32'(imem_addr2), 32'hFFFFFF);
        tick(); #1;
        chk("c2_valid", 32'(valid),      32'd1);
        chk("c2_pc",    32'(instr_pc),   32'h0);
        chk("c2_instr", 32'(instr),      32'h0);
        chk("c2_addr",  32'(imem_addr),  32'h2);
        chk("c2_addr2", 32'(imem_addr2), 32'h000000);
        chk("c2_pc2",   32'(instr_pc2),  32'hFFFFFE);
        chk("c2_ins2",  32'(instr2),     32'hFFFE);
        for (int k = 3; k <= 6; k++) begin
            tick(); #1;
            chk("st_pc",    32'(instr_pc),  32'(k - 2));
            chk("st_instr", 32'(instr),     32'(k - 2));
            chk("st_addr",  32'(imem_addr), 32'(k));
        end

        // ---- consumer stalls: buffer fills, fetch stops ----
        tick(); next_instr = 1'b0; #1;
        chk("c7_pc",   32'(instr_pc),  32'h5);
        chk("c7_addr", 32'(imem_addr), 32'h7);
        tick(); #1;
        chk("c8_en",   32'(imem_en),   32'd1);
        chk("c8_addr", 32'(imem_addr), 32'h8);
        tick(); #1;
        chk("c9_en",   32'(imem_en),   32'd0);
        tick(); #1;
        chk("c10_en",  32'(imem_en),   32'd0);
        chk("c10_vld", 32'(valid),     32'd1);
        tick(); next_instr = 1'b1; #1;
        chk("c11_pc",  32'(instr_pc),  32'h5);
        chk("c11_en",  32'(imem_en),   32'd0);
        tick(); #1;
        chk("c12_pc",  32'(instr_pc),  32'h6);
        chk("c12_en",  32'(imem_en),   32'd1);
        chk("c12_addr",32'(imem_addr), 32'h9);
        tick(); #1;
        chk("c13_pc",  32'(instr_pc),  32'h7);
        chk("c13_addr",32'(imem_addr), 32'hA);
        tick(); #1;
        chk("c14_pc",  32'(instr_pc),  32'h8);
        tick(); #1;
        chk("c15_pc",  32'(instr_pc),  32'h9);

        // ---- jump while streaming, stale word in flight ----
        tick(); jump = 1'b1; jdata = 24'h000100; #1;
        chk("j1_pc",   32'(instr_pc),  32'hA);
        chk("j1_en",   32'(imem_en),   32'd1);
        chk("j1_addr", 32'(imem_addr), 32'h100);
        tick(); jump = 1'b0; #1;
        chk("j1_flush",32'(valid),     32'd0);
        chk("j1_nxt",  32'(imem_addr), 32'h101);
        tick(); #1;
        chk("j1_vld",  32'(valid),     32'd1);
        chk("j1_tpc",  32'(instr_pc),  32'h100);
        chk("j1_tins", 32'(instr),     32'h0100);
        chk("j1_a2",   32'(imem_addr), 32'h102);
        tick(); #1;
        chk("j1_tpc2", 32'(instr_pc),  32'h101);

        // ---- fill buffer, then jump with pop on a full buffer ----
        tick(); next_instr = 1'b0; #1;
        chk("f_pc",    32'(instr_pc),  32'h102);
        chk("f_addr",  32'(imem_addr), 32'h104);
        tick(); tick(); #1;
        chk("f_en22",  32'(imem_en),   32'd0);
        tick(); #1;
        chk("f_en23",  32'(imem_en),   32'd0);
        chk("f_head",  32'(instr_pc),  32'h102);
        tick(); jump = 1'b1; jdata = 24'h000200; next_instr = 1'b1; #1;
        chk("j2_en",   32'(imem_en),   32'd1);
        chk("j2_addr", 32'(imem_addr), 32'h200);
        tick(); jump = 1'b0; #1;
        chk("j2_flush",32'(valid),     32'd0);
        chk("j2_nxt",  32'(imem_addr), 32'h201);
        tick(); #1;
        chk("j2_tpc",  32'(instr_pc),  32'h200);

        // ---- halt mid-stream ----
        tick(); run = 1'b0; #1;
        chk("h_en",    32'(imem_en),   32'd0);
        chk("h_pc",    32'(instr_pc),  32'h201);
        tick(); #1;
        chk("h_land",  32'(instr_pc),  32'h202);
        chk("h_vld",   32'(valid),     32'd1);
        chk("h_en2",   32'(imem_en),   32'd0);
        tick(); #1;
        chk("h_drain", 32'(valid),     32'd0);
        tick(); jump = 1'b1; jdata = 24'h000020; #1;
        chk("hj_en",   32'(imem_en),   32'd0);
        tick(); jump = 1'b0; run = 1'b1; #1;
        chk("hj_en2",  32'(imem_en),   32'd1);
        chk("hj_addr", 32'(imem_addr), 32'h20);
        tick(); #1;
        chk("hj_a2",   32'(imem_addr), 32'h21);
        tick(); #1;
        chk("hj_tpc",  32'(instr_pc),  32'h20);
        chk("hj_tins", 32'(instr),     32'h0020);

        // ---- back-to-back jumps: last wins, earlier target never appears ----
        tick(); jump = 1'b1; jdata = 24'h000300; #1;
        chk("bb_a1",   32'(imem_addr), 32'h300);
        tick(); jdata = 24'h000400; #1;
        chk("bb_a2",   32'(imem_addr), 32'h400);
        chk("bb_v1",   32'(valid),     32'd0);
        tick(); jump = 1'b0; #1;
        chk("bb_v2",   32'(valid),     32'd0);
        chk("bb_a3",   32'(imem_addr), 32'h401);
        tick(); #1;
        chk("bb_tpc",  32'(instr_pc),  32'h400);

        // ---- asynchronous reset mid-stream ----
        tick(); #1;
        chk("mr_pre",  32'(valid),     32'd1);
        rst_n = 1'b0; #1;
        chk("mr_vld",  32'(valid),     32'd0);
        chk("mr_en",   32'(imem_en),   32'd0);
        chk("mr_vld2", 32'(valid2),    32'd0);
        chk("mr_en2",  32'(imem_en2),  32'd0);
        tick(); tick();
        rst_n = 1'b1; #1;
        chk("mr_addr", 32'(imem_addr), 32'h0);
        chk("mr_a2",   32'(imem_addr2),32'hFFFFFE);
        chk("mr_v0",   32'(valid),     32'd0);
        tick(); #1;
        chk("mr_addr1",32'(imem_addr), 32'h1);
        chk("mr_v1",   32'(valid),     32'd0);
        tick(); #1;
        chk("mr_tpc",  32'(instr_pc),  32'h0);
        chk("mr_tins", 32'(instr),     32'h0);
        chk("mr_tpc2", 32'(instr_pc2), 32'hFFFFFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
